// File: rtl/priority_irq_ctrl_v_if.sv
// Handshake bundle for priority_irq_ctrl_v: request/ready inputs and the
// (code, valid) offer with pending and drop status.
// Optional: PRIO_IRQ_MASK_EN adds the i_mask input.
interface priority_irq_ctrl_v_if #(
    parameter int N_REQ  = 4,
    parameter int CODE_W = 2
);
    logic [N_REQ-1:0]  i_req;
    logic              i_ready;
    logic [CODE_W-1:0] o_code;
    logic              o_valid;
    logic [N_REQ-1:0]  o_pending;
    logic              o_drop;
`ifdef PRIO_IRQ_MASK_EN
    logic [N_REQ-1:0]  i_mask;

    // Controller side
    modport master (
        input  i_req, i_ready, i_mask,
        output o_code, o_valid, o_pending, o_drop
    );

    // Event source / consumer side
    modport slave (
        output i_req, i_ready, i_mask,
        input  o_code, o_valid, o_pending, o_drop
    );
`else
    // Controller side
    modport master (
        input  i_req, i_ready,
        output o_code, o_valid, o_pending, o_drop
    );

    // Event source / consumer side
    modport slave (
        output i_req, i_ready,
        input  o_code, o_valid, o_pending, o_drop
    );
`endif
endinterface

// File: rtl/priority_irq_ctrl_v.sv
// priority_irq_ctrl_v: latches request pulses into sticky pending bits,
// arbitrates them with line 0 highest, and offers the winner as a registered
// code with valid/ready. An offer holds until accepted (no re-arbitration).
// Optional: PRIO_IRQ_MASK_EN excludes masked lines from arbitration.
module priority_irq_ctrl_v #(
    parameter int N_REQ  = 4,
    parameter int CODE_W = 2
) (
    input logic                  i_clk,
    input logic                  i_rst_n,
    priority_irq_ctrl_v_if.master bus
);

    typedef enum logic {IDLE = 1'b0, OFFER = 1'b1} state_t;

    state_t            state, state_next;
    logic [N_REQ-1:0]  pending_p0, pending_next, clr, elig;
    logic [CODE_W-1:0] code_p0, code_next, win;
    logic              drop_p0, drop_next, accept;

    function automatic logic [CODE_W-1:0] lowest_set(input logic [N_REQ-1:0] v);
        logic [CODE_W-1:0] idx;
        idx = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (v[i]) idx = CODE_W'(i);
        end
        return idx;
    endfunction

    // Ready only counts while an offer is on the bus
    assign accept = (state == OFFER) && bus.i_ready;

    // Pending update (set wins over clear), drop detect and arbitration
    always_comb begin
        clr = '0;
        if (accept) clr[code_p0] = 1'b1;
        pending_next = (pending_p0 & ~clr) | bus.i_req;
        drop_next    = |(bus.i_req & pending_p0 & ~clr);
`ifdef PRIO_IRQ_MASK_EN
        elig = pending_next & ~bus.i_mask;
`else
        elig = pending_next;
`endif
        win = lowest_set(elig);
    end

    // State register
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) state <= IDLE;
        else          state <= state_next;
    end

    // Pending vector, offered code and drop pulse registers
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            pending_p0 <= '0;
            code_p0    <= '0;
            drop_p0    <= 1'b0;
        end else begin
            pending_p0 <= pending_next;
            code_p0    <= code_next;
            drop_p0    <= drop_next;
        end
    end

    // Next state: leave IDLE when something is eligible, leave OFFER on an
    // accept that leaves nothing eligible
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (elig != '0) state_next = OFFER;
            OFFER:   if (bus.i_ready && (elig == '0)) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Next offered code: load the winner from IDLE or on accept, else hold
    always_comb begin
        code_next = code_p0;
        if (((state == IDLE) || accept) && (elig != '0)) code_next = win;
    end

    assign bus.o_code    = code_p0;
    assign bus.o_valid   = (state == OFFER);
    assign bus.o_pending = pending_p0;
    assign bus.o_drop    = drop_p0;

endmodule

// File: tb/tb_priority_irq_ctrl_v.sv
// Scoreboard bench for priority_irq_ctrl_v: directed scenarios plus random
// traffic, checked against a line-by-line behavioural model.
module tb_priority_irq_ctrl_v;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    priority_irq_ctrl_v_if #(.N_REQ(4), .CODE_W(2)) bus ();

    priority_irq_ctrl_v #(.N_REQ(4), .CODE_W(2)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus.master)
    );

    typedef struct {
        logic       v;
        logic [1:0] c;
        logic [3:0] p;
        logic       d;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model state: per-line pending flags and the current offer
    bit         mp[4];
    bit         mv;
    logic [1:0] mc;

    task automatic chk(input string nm, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d at %0t", nm, act, req, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) mp[i] = 1'b0;
        mv = 1'b0;
        mc = 2'd0;
    endtask

    // One clock edge of the controller, described line by line
    task automatic model_step(input logic [3:0] req, input logic rdy, input logic [3:0] msk);
        int   cl;
        bit   acc;
        bit   d;
        exp_t e;
        acc = mv && rdy;
        cl  = acc ? int'(mc) : -1;
        d   = 1'b0;
        for (int i = 0; i < 4; i++) if (req[i] && mp[i] && i != cl) d = 1'b1;
        for (int i = 0; i < 4; i++) mp[i] = (mp[i] && i != cl) || req[i];
        if (!mv || acc) begin
            mv = 1'b0;
            for (int i = 3; i >= 0; i--) begin
                if (mp[i] && !msk[i]) begin
                    mv = 1'b1;
                    mc = 2'(i);
                end
            end
        end
        e.v = mv;
        e.c = mc;
        for (int i = 0; i < 4; i++) e.p[i] = mp[i];
        e.d = d;
        q.push_back(e);
    endtask

    // Called at negedge+1: drive inputs, predict, then advance one cycle
    task automatic cyc(input logic [3:0] req, input logic rdy, input logic [3:0] msk);
        bus.i_req   = req;
        bus.i_ready = rdy;
`ifdef PRIO_IRQ_MASK_EN
        bus.i_mask  = msk;
        model_step(req, rdy, msk);
`else
        model_step(req, rdy, 4'b0000 & msk);
`endif
        @(negedge clk);
        #1;
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, "_valid"},   int'(bus.o_valid),   0);
        chk({tag, "_pending"}, int'(bus.o_pending), 0);
        chk({tag, "_code"},    int'(bus.o_code),    0);
        chk({tag, "_drop"},    int'(bus.o_drop),    0);
    endtask

    // Monitor: pop the prediction for the edge just past and compare
    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            chk("valid",   int'(bus.o_valid),   int'(e.v));
            if (e.v) chk("code", int'(bus.o_code), int'(e.c));
            else     chk("code_hold", int'(bus.o_code), int'(e.c));
            chk("pending", int'(bus.o_pending), int'(e.p));
            chk("drop",    int'(bus.o_drop),    int'(e.d));
        end
    end

    initial begin
        logic [3:0] r, m;
        model_reset();
        bus.i_req   = 4'b1111;
        bus.i_ready = 1'b0;
`ifdef PRIO_IRQ_MASK_EN
        bus.i_mask  = 4'b0000;
`endif
        // Reset held with all requests asserted
        repeat (3) @(negedge clk);
        #1;
        check_reset_state("rst");
        rst_n = 1'b1;

        // Two requests served back to back, then idle
        cyc(4'b1010, 1'b1, 4'b0000);
        cyc(4'b0000, 1'b1, 4'b0000);
        cyc(4'b0000, 1'b1, 4'b0000);
        cyc(4'b0000, 1'b0, 4'b0000);

        // Held offer ignores a higher-priority arrival
        cyc(4'b0100, 1'b0, 4'b0000);
        repeat (4) cyc(4'b0000, 1'b0, 4'b0000);
        cyc(4'b0001, 1'b0, 4'b0000);
        cyc(4'b0000, 1'b1, 4'b0000);
        cyc(4'b0000, 1'b1, 4'b0000);
        cyc(4'b0000, 1'b0, 4'b0000);

        // Drop on a pending line; re-request in the accept cycle
        cyc(4'b0011, 1'b0, 4'b0000);
        cyc(4'b0010, 1'b0, 4'b0000);
        cyc(4'b0000, 1'b0, 4'b0000);
        cyc(4'b0000, 1'b1, 4'b0000);
        cyc(4'b0010, 1'b1, 4'b0000);
        cyc(4'b0000, 1'b1, 4'b0000);
        cyc(4'b0000, 1'b1, 4'b0000);

        // All lines pending served 0,1,2,3
        cyc(4'b1111, 1'b1, 4'b0000);
        repeat (5) cyc(4'b0000, 1'b1, 4'b0000);

        // Asynchronous reset in the middle of an offer
        cyc(4'b0111, 1'b0, 4'b0000);
        rst_n = 1'b0;
        #1;
        chk("async_valid",   int'(bus.o_valid),   0);
        chk("async_pending", int'(bus.o_pending), 0);
        model_reset();
        bus.i_req = 4'b1111;
        repeat (2) @(negedge clk);
        #1;
        check_reset_state("rst2");
        rst_n = 1'b1;

`ifdef PRIO_IRQ_MASK_EN
        // Masked line latches but is not offered; unmasking does not preempt
        cyc(4'b0101, 1'b0, 4'b0001);
        cyc(4'b0000, 1'b0, 4'b0000);
        cyc(4'b0000, 1'b1, 4'b0000);
        cyc(4'b0000, 1'b1, 4'b0000);
        cyc(4'b0000, 1'b0, 4'b0000);
`endif

        // Random traffic
        for (int n = 0; n < 600; n++) begin
            r = 4'($urandom_range(0, 15) & $urandom_range(0, 15));
            m = 4'($urandom_range(0, 15) & $urandom_range(0, 15) & $urandom_range(0, 15));
            cyc(r, 1'($urandom_range(0, 1)), m);
        end
        repeat (8) cyc(4'b0000, 1'b1, 4'b0000);

        chk("sb_empty", q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Watchdog
    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

endmodule
